wb_master_sequencer: RTL and testbench

Wishbone master controller for the PACKET2MESSAGE stage. Pulls the head message from the message queue and runs it as a single or incrementing-burst Wishbone cycle. Drives the queue's chunk-advance (`next_data`), restart (`retry`) and pop (`message_transmitted`) strobes. Also handles bus request/grant, slave retry with bounded back-off, error and timeout.

---
 rtl/wb_master_sequencer_pkg.sv | 30 +++
 rtl/wb_master_sequencer_timer.sv | 40 ++++
 rtl/wb_master_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_wb_master_sequencer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_master_sequencer_pkg.sv
// Shared constants for the PACKET2MESSAGE Wishbone master sequencer.
// Holds the bus widths, the Wishbone cycle type identifier codes, the FSM state
// encodings and a helper that selects the CTI code for a beat.
package wb_master_sequencer_pkg;

  localparam int unsigned BUS_ADDRESS_WIDTH = 32;
  localparam int unsigned BUS_DATA_WIDTH    = 32;
  localparam int unsigned BUS_SEL_WIDTH     = BUS_DATA_WIDTH / 8;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StReq     = 3'd1;
  localparam logic [2:0] StXfer    = 3'd2;
  localparam logic [2:0] StRelease = 3'd3;
  localparam logic [2:0] StBackoff = 3'd4;

  // Single-beat messages run as classic cycles; bursts mark their final beat.
  function automatic logic [2:0] cti_code(input logic single, input logic last);
    if (single) begin
      return CTI_CLASSIC;
    end else if (last) begin
      return CTI_EOB;
    end
    return CTI_INCR;
  endfunction

endpackage

// File: rtl/wb_master_sequencer_timer.sv
// Loadable down-counter shared by the per-beat timeout and the retry back-off.
// Ports:
//   clk_i, rst_ni  - clock, asynchronous active-low reset
//   load_i         - load load_val_i (has priority over dec_i)
//   load_val_i     - value to load
//   dec_i          - decrement by one, saturating at zero
//   expired_o      - counter is zero
module wb_master_sequencer_timer #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             dec_i,
  output logic             expired_o
);

  logic [Width-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == '0);

endmodule

// File: rtl/wb_master_sequencer.sv
// Wishbone master for the PACKET2MESSAGE stage. Takes the head message of the
// queue and runs it as a single or incrementing-burst Wishbone cycle.
// Ports:
//   clk, rst                    - clock, asynchronous active-low reset
//   r_bus_arbitration_i         - queue has a message at its head
//   address_i/data_i/sel_i      - head message base address, current chunk, byte select
//   transaction_type_i          - 1 = write, 0 = read
//   burst_lenght_i              - beats in the message (>= 1)
//   next_data_o/retry_o         - advance / rewind the queue chunk pointer (pulses)
//   message_transmitted_o       - pop the queue head (pulse)
//   bus_req_o/bus_gnt_i         - arbiter handshake
//   CYC_O..CTI_O, DAT_I, ACK_I/ERR_I/RTY_I - Wishbone master interface
//   rd_data_o/rd_valid_o/rd_last_o - captured read beat
//   error_o                     - message dropped (pulse)
module wb_master_sequencer
  import wb_master_sequencer_pkg::*;
#(
  parameter int unsigned N_BITS_BURST_LENGHT = 7,
  parameter int unsigned N_BITS_TIMER        = 8,
  parameter int unsigned TIMEOUT_CYCLES      = 255,
  parameter int unsigned BACKOFF_CYCLES      = 16,
  parameter int unsigned MAX_RETRIES         = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           r_bus_arbitration_i,
  input  logic [BUS_ADDRESS_WIDTH-1:0]   address_i,
  input  logic [BUS_DATA_WIDTH-1:0]      data_i,
  input  logic [BUS_SEL_WIDTH-1:0]       sel_i,
  input  logic                           transaction_type_i,
  input  logic [N_BITS_BURST_LENGHT-1:0] burst_lenght_i,
  output logic                           next_data_o,
  output logic                           retry_o,
  output logic                           message_transmitted_o,
  output logic                           bus_req_o,
  input  logic                           bus_gnt_i,
  output logic                           CYC_O,
  output logic                           STB_O,
  output logic                           WE_O,
  output logic [BUS_ADDRESS_WIDTH-1:0]   ADR_O,
  output logic [BUS_DATA_WIDTH-1:0]      DAT_O,
  output logic [BUS_SEL_WIDTH-1:0]       SEL_O,
  output logic [2:0]                     CTI_O,
  input  logic [BUS_DATA_WIDTH-1:0]      DAT_I,
  input  logic                           ACK_I,
  input  logic                           ERR_I,
  input  logic                           RTY_I,
  output logic [BUS_DATA_WIDTH-1:0]      rd_data_o,
  output logic                           rd_valid_o,
  output logic                           rd_last_o,
  output logic                           error_o
);

  localparam int unsigned BeatShift = $clog2(BUS_DATA_WIDTH / 8);
  localparam int unsigned RetryW    = $clog2(MAX_RETRIES + 2);
  // Timer loads N-1 and expires at zero, so a wait lasts exactly N cycles.
  localparam logic [N_BITS_TIMER-1:0] TimeoutLoad = N_BITS_TIMER'(TIMEOUT_CYCLES - 1);
  localparam logic [N_BITS_TIMER-1:0] BackoffLoad = N_BITS_TIMER'(BACKOFF_CYCLES - 1);

  logic [2:0]                     state_d, state_q;
  logic [N_BITS_BURST_LENGHT-1:0] beat_d, beat_q;
  logic [RetryW-1:0]              retry_d, retry_q;
  logic [BUS_DATA_WIDTH-1:0]      rd_data_d, rd_data_q;
  logic                           rd_last_d, rd_last_q;

  logic                      tmr_load, tmr_dec, tmr_expired;
  logic [N_BITS_TIMER-1:0]   tmr_load_val;
  logic                      in_xfer, last_beat, drop;
  logic [BUS_ADDRESS_WIDTH-1:0] beat_offset;

  wb_master_sequencer_timer #(
    .Width (N_BITS_TIMER)
  ) u_timer (
    .clk_i      (clk),
    .rst_ni     (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_load_val),
    .dec_i      (tmr_dec),
    .expired_o  (tmr_expired)
  );

  assign in_xfer     = (state_q == StXfer);
  assign last_beat   = (beat_q == (burst_lenght_i - N_BITS_BURST_LENGHT'(1)));
  assign beat_offset = BUS_ADDRESS_WIDTH'(beat_q) << BeatShift;

  always_comb begin
    state_d               = state_q;
    beat_d                = beat_q;
    retry_d               = retry_q;
    rd_data_d             = rd_data_q;
    rd_last_d             = rd_last_q;
    tmr_load              = 1'b0;
    tmr_load_val          = '0;
    tmr_dec               = 1'b0;
    drop                  = 1'b0;
    next_data_o           = 1'b0;
    retry_o               = 1'b0;
    message_transmitted_o = 1'b0;
    rd_valid_o            = 1'b0;
    error_o               = 1'b0;

    case (state_q)
      StIdle: begin
        if (r_bus_arbitration_i) state_d = StReq;
      end
      StReq: begin
        if (bus_gnt_i) begin
          state_d      = StXfer;
          tmr_load     = 1'b1;
          tmr_load_val = TimeoutLoad;
        end
      end
      StXfer: begin
        // Termination priority: ERR > RTY > timeout > ACK.
        if (ERR_I) begin
          drop = 1'b1;
        end else if (RTY_I) begin
          if (retry_q < RetryW'(MAX_RETRIES)) begin
            retry_o      = 1'b1;
            beat_d       = '0;
            retry_d      = retry_q + RetryW'(1);
            state_d      = StBackoff;
            tmr_load     = 1'b1;
            tmr_load_val = BackoffLoad;
          end else begin
            drop = 1'b1;
          end
        end else if (tmr_expired) begin
          drop = 1'b1;
        end else if (ACK_I) begin
          if (!transaction_type_i) begin
            rd_valid_o = 1'b1;
            rd_data_d  = DAT_I;
            rd_last_d  = last_beat;
          end
          if (last_beat) begin
            message_transmitted_o = 1'b1;
            beat_d                = '0;
            retry_d               = '0;
            state_d               = StRelease;
          end else begin
            next_data_o  = 1'b1;
            beat_d       = beat_q + N_BITS_BURST_LENGHT'(1);
            tmr_load     = 1'b1;
            tmr_load_val = TimeoutLoad;
          end
        end else begin
          tmr_dec = 1'b1;
        end

        if (drop) begin
          error_o               = 1'b1;
          message_transmitted_o = 1'b1;
          beat_d                = '0;
          retry_d               = '0;
          state_d               = StRelease;
        end
      end
      // One dead cycle lets the queue head advance before arbitration is resampled.
      StRelease: state_d = StIdle;
      StBackoff: begin
        if (tmr_expired) begin
          state_d = StReq;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      beat_q    <= '0;
      retry_q   <= '0;
      rd_data_q <= '0;
      rd_last_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      retry_q   <= retry_d;
      rd_data_q <= rd_data_d;
      rd_last_q <= rd_last_d;
    end
  end

  assign bus_req_o = in_xfer || (state_q == StReq);
  assign CYC_O     = in_xfer;
  assign STB_O     = in_xfer;
  assign WE_O      = in_xfer & transaction_type_i;
  assign ADR_O     = in_xfer ? (address_i + beat_offset) : '0;
  assign DAT_O     = in_xfer ? data_i : '0;
  assign SEL_O     = in_xfer ? sel_i : '0;
  assign CTI_O     = in_xfer ? cti_code(burst_lenght_i == N_BITS_BURST_LENGHT'(1), last_beat)
                             : CTI_CLASSIC;
  assign rd_data_o = rd_data_q;
  assign rd_last_o = rd_last_q;

endmodule

// File: tb/tb_wb_master_sequencer.sv
// Directed bench for wb_master_sequencer with a tiny queue model that supplies
// data_i from a chunk pointer moved by next_data_o / retry_o / pops.
module tb_wb_master_sequencer;

  logic        clk;
  logic        rst;
  logic        r_bus_arbitration_i;
  logic [31:0] address_i;
  logic [31:0] data_i;
  logic [3:0]  sel_i;
  logic        transaction_type_i;
  logic [6:0]  burst_lenght_i;
  logic        next_data_o, retry_o, message_transmitted_o, bus_req_o, bus_gnt_i;
  logic        CYC_O, STB_O, WE_O;
  logic [31:0] ADR_O, DAT_O, DAT_I, rd_data_o;
  logic [3:0]  SEL_O;
  logic [2:0]  CTI_O;
  logic        ACK_I, ERR_I, RTY_I, rd_valid_o, rd_last_o, error_o;

  int passed = 0;
  int total  = 0;

  logic        clr;
  logic [31:0] chunk;
  int          next_cnt, retry_cnt, pop_cnt, err_cnt;

  wb_master_sequencer dut (
    .clk                   (clk),
    .rst                   (rst),
    .r_bus_arbitration_i   (r_bus_arbitration_i),
    .address_i             (address_i),
    .data_i                (data_i),
    .sel_i                 (sel_i),
    .transaction_type_i    (transaction_type_i),
    .burst_lenght_i        (burst_lenght_i),
    .next_data_o           (next_data_o),
    .retry_o               (retry_o),
    .message_transmitted_o (message_transmitted_o),
    .bus_req_o             (bus_req_o),
    .bus_gnt_i             (bus_gnt_i),
    .CYC_O                 (CYC_O),
    .STB_O                 (STB_O),
    .WE_O                  (WE_O),
    .ADR_O                 (ADR_O),
    .DAT_O                 (DAT_O),
    .SEL_O                 (SEL_O),
    .CTI_O                 (CTI_O),
    .DAT_I                 (DAT_I),
    .ACK_I                 (ACK_I),
    .ERR_I                 (ERR_I),
    .RTY_I                 (RTY_I),
    .rd_data_o             (rd_data_o),
    .rd_valid_o            (rd_valid_o),
    .rd_last_o             (rd_last_o),
    .error_o               (error_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign data_i = 32'hD000_0000 + chunk;

  // Queue model and strobe counters.
  always @(posedge clk) begin
    if (clr) begin
      chunk <= '0; next_cnt <= 0; retry_cnt <= 0; pop_cnt <= 0; err_cnt <= 0;
    end else begin
      if (next_data_o) next_cnt <= next_cnt + 1;
      if (retry_o) retry_cnt <= retry_cnt + 1;
      if (message_transmitted_o) pop_cnt <= pop_cnt + 1;
      if (error_o) err_cnt <= err_cnt + 1;
      if (retry_o || message_transmitted_o) chunk <= '0;
      else if (next_data_o) chunk <= chunk + 1;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Waits (bounded) for a bus request, then grants; leaves the DUT in its first XFER cycle.
  task automatic regrant(input string tag, output int waited);
    waited = 0;
    while (!bus_req_o && waited < 40) begin
      tick();
      waited++;
    end
    chk(tag, bus_req_o, 1'b1);
    bus_gnt_i = 1'b1;
    tick();
    bus_gnt_i = 1'b0;
    settle();
  endtask

  logic [31:0] adr_exp [4] = '{32'h100, 32'h104, 32'h108, 32'h10C};
  logic [2:0]  cti_exp [4] = '{3'b010, 3'b010, 3'b010, 3'b111};
  int          w;
  int          n;

  initial begin
    rst = 1'b0; clr = 1'b1;
    r_bus_arbitration_i = 1'b0; address_i = '0; sel_i = '0; transaction_type_i = 1'b0;
    burst_lenght_i = 7'd1; bus_gnt_i = 1'b0; DAT_I = '0;
    ACK_I = 1'b0; ERR_I = 1'b0; RTY_I = 1'b0;
    #12;
    chk("reset_cyc", CYC_O, 1'b0);
    chk("reset_req", bus_req_o, 1'b0);
    chk("reset_rd_data", rd_data_o, 32'h0);
    chk("reset_rd_last", rd_last_o, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    clr = 1'b0;

    // Single write, grant two cycles after the request.
    address_i = 32'h200; sel_i = 4'hF; transaction_type_i = 1'b1; burst_lenght_i = 7'd1;
    r_bus_arbitration_i = 1'b1;
    tick();
    chk("single_req", bus_req_o, 1'b1);
    chk("single_req_cyc", CYC_O, 1'b0);
    tick();
    bus_gnt_i = 1'b1;
    tick();
    bus_gnt_i = 1'b0;
    settle();
    chk("single_cyc", CYC_O, 1'b1);
    chk("single_we", WE_O, 1'b1);
    chk("single_adr", ADR_O, 32'h200);
    chk("single_cti", CTI_O, 3'b000);
    chk("single_dat", DAT_O, 32'hD000_0000);
    ACK_I = 1'b1;
    settle();
    chk("single_pop", message_transmitted_o, 1'b1);
    chk("single_next", next_data_o, 1'b0);
    tick();
    ACK_I = 1'b0; r_bus_arbitration_i = 1'b0;
    settle();
    chk("single_release_cyc", CYC_O, 1'b0);
    chk("single_release_req", bus_req_o, 1'b0);
    tick();
    tick();
    chk("single_idle_req", bus_req_o, 1'b0);
    chk("single_pop_cnt", pop_cnt, 1);
    chk("single_next_cnt", next_cnt, 0);

    // 4-beat write burst at 0x100.
    clr = 1'b1; tick(); clr = 1'b0;
    address_i = 32'h100; burst_lenght_i = 7'd4; r_bus_arbitration_i = 1'b1;
    regrant("burst_req", w);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("burst_adr%0d", i), ADR_O, adr_exp[i]);
      chk($sformatf("burst_cti%0d", i), {29'd0, CTI_O}, {29'd0, cti_exp[i]});
      chk($sformatf("burst_dat%0d", i), DAT_O, 32'hD000_0000 + i);
      ACK_I = 1'b1;
      tick();
      ACK_I = 1'b0;
      settle();
    end
    r_bus_arbitration_i = 1'b0;
    chk("burst_release_cyc", CYC_O, 1'b0);
    chk("burst_next_cnt", next_cnt, 3);
    chk("burst_pop_cnt", pop_cnt, 1);
    tick(); tick();

    // RTY on the second beat, then repeated RTYs until the message is dropped.
    clr = 1'b1; tick(); clr = 1'b0;
    r_bus_arbitration_i = 1'b1;
    regrant("rty_req", w);
    ACK_I = 1'b1;
    tick();
    ACK_I = 1'b0; RTY_I = 1'b1;
    settle();
    chk("rty_adr_beat1", ADR_O, 32'h104);
    chk("rty1_retry", retry_o, 1'b1);
    chk("rty1_error", error_o, 1'b0);
    chk("rty1_pop", message_transmitted_o, 1'b0);
    tick();
    RTY_I = 1'b0;
    n = 0;
    while (!bus_req_o && n < 40) begin
      chk("backoff_cyc", CYC_O, 1'b0);
      n++;
      tick();
    end
    chk("backoff_len", n, 16);
    regrant("rty_rereq", w);
    chk("rty_restart_adr", ADR_O, 32'h100);
    chk("rty_restart_dat", DAT_O, 32'hD000_0000);
    for (int r = 0; r < 3; r++) begin
      RTY_I = 1'b1;
      settle();
      if (r < 2) begin
        chk($sformatf("rty%0d_retry", r + 2), retry_o, 1'b1);
        chk($sformatf("rty%0d_error", r + 2), error_o, 1'b0);
        tick();
        RTY_I = 1'b0;
        regrant("rty_loop_req", w);
      end else begin
        chk("rty4_retry", retry_o, 1'b0);
        chk("rty4_error", error_o, 1'b1);
        chk("rty4_pop", message_transmitted_o, 1'b1);
        tick();
        RTY_I = 1'b0;
      end
    end
    r_bus_arbitration_i = 1'b0;
    settle();
    chk("rty_drop_cyc", CYC_O, 1'b0);
    chk("rty_retry_cnt", retry_cnt, 3);
    chk("rty_err_cnt", err_cnt, 1);
    chk("rty_pop_cnt", pop_cnt, 1);
    tick(); tick();

    // Slave never answers: timeout on the 255th STB cycle.
    r_bus_arbitration_i = 1'b1; burst_lenght_i = 7'd1; address_i = 32'h500;
    regrant("to_req", w);
    n = 0;
    for (int k = 1; k <= 300; k++) begin
      if (STB_O && error_o) begin
        n = k;
        break;
      end
      tick();
    end
    chk("timeout_cycles", n, 255);
    chk("timeout_pop", message_transmitted_o, 1'b1);
    tick();
    r_bus_arbitration_i = 1'b0;
    settle();
    chk("timeout_cyc_low", CYC_O, 1'b0);
    tick(); tick();

    // ERR and ACK together: ERR wins.
    r_bus_arbitration_i = 1'b1; burst_lenght_i = 7'd2; address_i = 32'h400;
    regrant("errack_req", w);
    ERR_I = 1'b1; ACK_I = 1'b1;
    settle();
    chk("errack_error", error_o, 1'b1);
    chk("errack_next", next_data_o, 1'b0);
    chk("errack_pop", message_transmitted_o, 1'b1);
    tick();
    ERR_I = 1'b0; ACK_I = 1'b0; r_bus_arbitration_i = 1'b0;
    settle();
    chk("errack_cyc_low", CYC_O, 1'b0);
    tick(); tick();

    // 2-beat read, reset during the second beat.
    r_bus_arbitration_i = 1'b1; burst_lenght_i = 7'd2; address_i = 32'h300;
    transaction_type_i = 1'b0; DAT_I = 32'hCAFE_0001;
    regrant("rd_req", w);
    chk("rd_we", WE_O, 1'b0);
    ACK_I = 1'b1;
    settle();
    chk("rd_valid", rd_valid_o, 1'b1);
    tick();
    ACK_I = 1'b0;
    settle();
    chk("rd_data", rd_data_o, 32'hCAFE_0001);
    chk("rd_last_beat0", rd_last_o, 1'b0);
    chk("rd_adr_beat1", ADR_O, 32'h304);
    chk("rd_cti_beat1", {29'd0, CTI_O}, 32'd7);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_cyc", CYC_O, 1'b0);
    chk("rst_stb", STB_O, 1'b0);
    chk("rst_req", bus_req_o, 1'b0);
    chk("rst_rd_data", rd_data_o, 32'h0);
    tick();
    rst = 1'b1;
    tick();
    chk("rst_idle_to_req", bus_req_o, 1'b1);
    chk("rst_req_cyc", CYC_O, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
